link_arbiter: RTL and testbench

LINK_ARBITER -- requirements
Module: link_arbiter

---
 rtl/link_arbiter.sv | 97 +++++++++
 tb/tb_link_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/link_arbiter.sv
// link_arbiter: round-robin arbiter that hands one payload at a time to a serial transmitter and enforces frame plus gap timing
// Ports:
//   clk            system clock, rising edge
//   clr            asynchronous active-high reset
//   req0/data0     requester 0 level request and payload (held until ack0)
//   req1/data1     requester 1 level request and payload (held until ack1)
//   ack0/ack1      one-cycle capture acknowledge to the winning requester
//   tx_data        registered payload for the transmitter
//   tx_send        one-cycle start pulse to the transmitter
//   tx_src         source of the frame in flight
//   busy           high whenever the link is not idle
module link_arbiter #(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 100,
    parameter int FRAME_BITS   = 18,
    parameter int GAP_CYCLES   = 200
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_send,
    output logic             tx_src,
    output logic             busy
);
    localparam int FRAME_CYC = FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_MAX   = (FRAME_CYC > GAP_CYCLES) ? FRAME_CYC : GAP_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_tx_src, r_last, r_send;
    logic             w_any, w_win;

    assign w_any = req0 | req1;
    // On a tie the requester that did not win last time takes the link
    assign w_win = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tx_data <= '0;
            r_tx_src  <= 1'b0;
            r_last    <= 1'b1;
            r_send    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            // Start pulse trails the ack by one cycle so the two never overlap
            r_send  <= (r_state == LOAD);
            if (r_state == IDLE && w_any) begin
                r_tx_data <= w_win ? data1 : data0;
                r_tx_src  <= w_win;
                r_last    <= w_win;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        case (r_state)
            IDLE: w_next = w_any ? LOAD : IDLE;
            LOAD: begin
                w_next = FRAME;
                w_cnt  = CW'(FRAME_CYC - 1);
            end
            FRAME: begin
                w_next = (r_cnt == '0) ? GAP : FRAME;
                w_cnt  = (r_cnt == '0) ? CW'(GAP_CYCLES - 1) : r_cnt - CW'(1);
            end
            GAP: begin
                w_next = (r_cnt == '0) ? IDLE : GAP;
                w_cnt  = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ack0    = (r_state == LOAD) && !r_tx_src;
        ack1    = (r_state == LOAD) && r_tx_src;
        tx_send = r_send;
        tx_data = r_tx_data;
        tx_src  = r_tx_src;
        busy    = (r_state != IDLE);
    end
endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: scoreboard bench for link_arbiter driven by directed and random request traffic
module tb_link_arbiter;
    localparam int W   = 16;
    localparam int CPB = 4;
    localparam int FB  = 18;
    localparam int GC  = 8;
    localparam int FC  = FB * CPB;

    typedef struct {
        logic         src;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         ack0, ack1, tx_send, tx_src, busy;
    logic [W-1:0] tx_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t         q[$];
    int           free_at = 0;
    int           ack_cyc = -1;
    logic         ack_src = 1'b0;
    int           busy_lo = 1;
    int           busy_hi = 0;
    logic         last    = 1'b1;
    logic [W-1:0] mdl_data = '0;
    logic         mdl_src  = 1'b0;

    link_arbiter #(.WIDTH(W), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CYCLES(GC)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .tx_data(tx_data), .tx_send(tx_send), .tx_src(tx_src), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: timeline arithmetic. A grant at the end of cycle c
    // acks in c+1, sends in c+2, and the link is free again at c+2+FC+GC.
    always @(posedge clk) begin
        if (clr) begin
            q.delete();
            ack_cyc  = -1;
            busy_lo  = 1;
            busy_hi  = 0;
            free_at  = 0;
            last     = 1'b1;
            mdl_data = '0;
            mdl_src  = 1'b0;
        end else if (cyc >= free_at && (req0 || req1)) begin
            logic w;
            w        = (req0 && req1) ? ~last : req1;
            last     = w;
            mdl_src  = w;
            mdl_data = w ? data1 : data0;
            ack_cyc  = cyc + 1;
            ack_src  = w;
            q.push_back('{w, mdl_data, cyc + 2});
            busy_lo  = cyc + 1;
            busy_hi  = cyc + 1 + FC + GC;
            free_at  = cyc + 2 + FC + GC;
        end
        cyc++;
    end

    // Monitor: compares DUT outputs mid-cycle against the model and the send queue
    always @(negedge clk) begin
        check("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
        check("ack_send_excl", {31'd0, (ack0 | ack1) & tx_send}, 32'd0);
        if (clr) begin
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
            check("rst_send", {31'd0, tx_send}, 32'd0);
            check("rst_data", {16'd0, tx_data}, 32'd0);
            check("rst_src", {31'd0, tx_src}, 32'd0);
        end else begin
            logic exp_send;
            exp_send = (q.size() > 0) && (q[0].cyc == cyc);
            check("busy", {31'd0, busy}, {31'd0, cyc >= busy_lo && cyc <= busy_hi});
            check("ack0", {31'd0, ack0}, {31'd0, cyc == ack_cyc && !ack_src});
            check("ack1", {31'd0, ack1}, {31'd0, cyc == ack_cyc && ack_src});
            check("tx_data", {16'd0, tx_data}, {16'd0, mdl_data});
            check("tx_src", {31'd0, tx_src}, {31'd0, mdl_src});
            check("tx_send", {31'd0, tx_send}, {31'd0, exp_send});
            if (exp_send) begin
                exp_t e;
                e = q.pop_front();
                check("send_data", {16'd0, tx_data}, {16'd0, e.data});
                check("send_src", {31'd0, tx_src}, {31'd0, e.src});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_auto(input int n);
        repeat (n) begin
            step();
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
    endtask

    task automatic wait_ack0();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            seen = ack0;
        end
        check("ack0_timeout", {31'd0, seen}, 32'd1);
        req0 = 1'b0;
    endtask

    task automatic rand_req(inout logic r, inout logic [W-1:0] d, input logic a);
        if (r && a) r = ($urandom_range(3) == 0);
        else if (r && $urandom_range(199) == 0) r = 1'b0;
        else if (!r && $urandom_range(19) == 0) begin
            r = 1'b1;
            d = W'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) step();
        clr = 1'b0;
        repeat (3) step();
        // Single request from idle
        req0 = 1'b1; data0 = 16'hA5C3;
        wait_ack0();
        run_auto(90);
        // Both requesting straight out of reset
        clr = 1'b1; step();
        req0 = 1'b1; data0 = 16'h0001; req1 = 1'b1; data1 = 16'h0002;
        clr = 1'b0;
        run_auto(180);
        // Both held continuously across four frames
        req0 = 1'b1; data0 = 16'h1111; req1 = 1'b1; data1 = 16'h2222;
        repeat (4 * 82 + 5) step();
        req0 = 1'b0; req1 = 1'b0;
        run_auto(90);
        // req1 raised ten cycles into a frame
        req0 = 1'b1; data0 = 16'h0F0F;
        wait_ack0();
        repeat (11) step();
        req1 = 1'b1; data1 = 16'h3C5A;
        run_auto(170);
        // clr thirty cycles into a frame with req0 still held
        req0 = 1'b1; data0 = 16'h1234;
        wait_ack0();
        req0 = 1'b1;
        repeat (31) step();
        clr = 1'b1;
        repeat (2) step();
        clr = 1'b0;
        run_auto(100);
        // One-cycle req0 pulse during the gap
        req0 = 1'b1; data0 = 16'h5555;
        wait_ack0();
        repeat (76) step();
        req0 = 1'b1; data0 = 16'hDEAD;
        step();
        req0 = 1'b0;
        repeat (30) step();
        // Random traffic with occasional reset
        repeat (3000) begin
            step();
            rand_req(req0, data0, ack0);
            rand_req(req1, data1, ack1);
            clr = ($urandom_range(599) == 0);
        end
        clr = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (100) step();
        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
